// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: ALU op / funct codes and FSM encoding.
// Also holds small decode helpers used by issue-side hazard logic.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned FUNCT_W   = 6;

    localparam logic [ALU_OP_W-1:0] ALU_div     = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_rs_pass = 4'd10;

    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_RUN   = 2'd1,
        DIV_FIXUP = 2'd2
    } div_state_t;

    // True for any op that must stall while the divider is busy.
    function automatic logic needs_div_unit(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_div) || (op == ALU_rs_pass);
    endfunction

    // True for the DIV / DIVU funct codes; the second result is the signedness.
    function automatic logic [1:0] decode_div_funct(input logic [FUNCT_W-1:0] funct);
        return {(funct == FUNCT_DIV) || (funct == FUNCT_DIVU), funct == FUNCT_DIV};
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract divisor.
// Purely combinational; the caller owns all state.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // rem < divisor on entry, so the 33-bit difference sign alone decides restore.
    assign w_shift = {rem, quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, divisor};

    always_comb begin
        rem_next = w_shift[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            rem_next = w_trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider that owns the HI/LO registers.
// 32 restoring iterations on magnitudes, then one fixup cycle applies signs and writes HI/LO.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned        CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic             w_accept;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dividend;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; flush overrides everything, including a same-cycle start.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    w_next_state = DIV_RUN;
                    w_accept     = 1'b1;
                end
            end
            DIV_RUN: begin
                if (r_cnt == LAST_ITER) begin
                    w_next_state = DIV_FIXUP;
                end
            end
            DIV_FIXUP: w_next_state = DIV_IDLE;
            default:   w_next_state = DIV_IDLE;
        endcase
        if (flush) begin
            w_next_state = DIV_IDLE;
            w_accept     = 1'b0;
        end
    end

    assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

    div_step #(
        .WIDTH    (WIDTH)
    ) u_div_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_dvs),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    // Divide-by-zero bypasses sign fixup and reports the raw dividend in HI.
    always_comb begin
        w_lo_fix = r_neg_q ? (WIDTH'(0) - r_quo) : r_quo;
        w_hi_fix = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;
        if (r_div0) begin
            w_lo_fix = '1;
            w_hi_fix = r_dividend;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt      <= '0;
                r_rem      <= '0;
                r_quo      <= w_dvd_mag;
                r_dvs      <= w_dvs_mag;
                r_dividend <= dividend;
                r_neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r    <= is_signed & dividend[WIDTH-1];
                r_div0     <= (divisor == '0);
            end else if (!flush && r_state == DIV_RUN) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!flush && r_state == DIV_FIXUP) begin
                r_hi   <= w_hi_fix;
                r_lo   <= w_lo_fix;
                r_done <= 1'b1;
            end
        end
    end

    assign busy = (r_state != DIV_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed and small randomized checks of div_unit using an expected-result queue.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          failures;
    logic [63:0] exp_q[$];

    div_unit #(
        .WIDTH     (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} for a MIPS DIV/DIVU including div-by-zero and overflow.
    function automatic logic [63:0] ref_div(input logic [31:0] dvd, input logic [31:0] dvs,
                                            input logic sgn);
        int sd;
        int sv;
        if (dvs == 32'd0) return {dvd, 32'hFFFFFFFF};
        if (sgn) begin
            if (dvd == 32'h80000000 && dvs == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            sd = dvd;
            sv = dvs;
            return {32'(sd % sv), 32'(sd / sv)};
        end
        return {dvd % dvs, dvd / dvs};
    endfunction

    // Drive start for one cycle from the current negedge; returns at the next negedge (N1).
    task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                         input logic push_exp, input logic [31:0] ehi, input logic [31:0] elo);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = dvd;
        divisor   = dvs;
        if (push_exp) exp_q.push_back({ehi, elo});
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for done starting at negedge index cyc0 after issue; check result.
    task automatic wait_done(input int cyc0, input string tag);
        int          cyc;
        int          busy_low;
        logic [63:0] e;
        cyc      = cyc0;
        busy_low = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clock);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd34);
        check({tag, "_busy_run"}, 32'(busy_low), 32'd0);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
        check({tag, "_lo"}, lo, e[31:0]);
        check({tag, "_hi"}, hi, e[63:32]);
    endtask

    task automatic after_done(input string tag);
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (done === 1'b1) n++;
            @(negedge clock);
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          nd;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        issue(32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
        check("p100_busy_e0", {31'd0, busy}, 32'd1);
        wait_done(1, "p100_s");
        after_done("p100_s");

        issue(32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2);
        wait_done(1, "m100_s");
        after_done("m100_s");

        issue(32'hFFFFFF9C, 32'd7, 1'b0, 1'b1, 32'd2, 32'h24924916);
        wait_done(1, "m100_u");
        after_done("m100_u");

        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0, 32'h80000000);
        wait_done(1, "ovf");
        after_done("ovf");

        issue(32'h1234, 32'd0, 1'b1, 1'b1, 32'h1234, 32'hFFFFFFFF);
        wait_done(1, "div0");
        after_done("div0");

        issue(32'd100, 32'hFFFFFFF9, 1'b1, 1'b1, 32'd2, 32'hFFFFFFF2);
        wait_done(1, "neg_dvs");
        after_done("neg_dvs");

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
        repeat (4) @(negedge clock);
        issue(32'd9, 32'd3, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done(6, "ign_start");
        issue(32'd9, 32'd3, 1'b1, 1'b1, 32'd0, 32'd3);
        wait_done(1, "b2b");
        after_done("b2b");

        issue(32'd153, 32'd13, 1'b0, 1'b1, 32'hA, 32'hB);
        wait_done(1, "prior_ab");
        after_done("prior_ab");

        // Flush at cycle 10: no result, HI/LO kept.
        issue(32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        count_done(40, nd);
        check("flush_no_done", 32'(nd), 32'd0);
        check("flush_hi", hi, 32'hA);
        check("flush_lo", lo, 32'hB);

        // Flush and start together in IDLE: nothing starts.
        flush = 1'b1;
        issue(32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 32'd0);
        flush = 1'b0;
        check("fs_busy", {31'd0, busy}, 32'd0);
        count_done(40, nd);
        check("fs_no_done", 32'(nd), 32'd0);
        check("fs_lo", lo, 32'hB);

        // Reset at cycle 20 clears everything; next divide runs normally.
        issue(32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        issue(32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
        wait_done(1, "post_rst");
        after_done("post_rst");

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            s = 1'($urandom_range(0, 1));
            r = ref_div(a, b, s);
            issue(a, b, s, 1'b1, r[63:32], r[31:0]);
            wait_done(1, "rand");
            after_done("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
